// File: rtl/tff_pkg.sv
// Shared types and reset constants for the T flip-flop modulo counter.
package tff_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } tff_state_e;

    localparam int unsigned WidthDef = 4;

    localparam tff_state_e StateRst = StIdle;
    localparam logic       CellRst  = 1'b0;
    localparam logic       FlagRst  = 1'b0;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Requester / cell-bank signal bundle for tff_count_ctrl.
// The dir signal exists only when TFF_DOWN_COUNT_EN is defined.
interface tff_count_ctrl_if #(
    parameter int unsigned WIDTH = tff_pkg::WidthDef
) ();
    logic             start;
    logic [WIDTH-1:0] mod_val;
    logic             pause;
`ifdef TFF_DOWN_COUNT_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
`ifdef TFF_DOWN_COUNT_EN
        output dir,
`endif
        output start, mod_val, pause,
        input  t_vec, count, busy, done
    );

    modport slave (
`ifdef TFF_DOWN_COUNT_EN
        input  dir,
`endif
        input  start, mod_val, pause,
        output t_vec, count, busy, done
    );
endinterface

// File: rtl/tff_cell.sv
// T flip-flop with asynchronous active-low clear and a synchronous load.
module tff_cell import tff_pkg::*; (
    input  logic clk,
    input  logic clr_n,
    input  logic t,
    input  logic d,
    input  logic ld,
    output logic q
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (t) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= CellRst;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller driving a bank of WIDTH T flip-flop cells as a modulo counter.
// Define TFF_DOWN_COUNT_EN to add the dir input and down-count mode.
module tff_count_ctrl import tff_pkg::*; #(
    parameter int unsigned WIDTH = WidthDef
) (
    input logic              clk,
    input logic              clr_n,
    tff_count_ctrl_if.slave  bus
);
    tff_state_e       state_d, state_q;
    logic [WIDTH-1:0] term_d, term_q;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] ld_val;
    logic             ld;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] end_val;
    logic             down;
`ifdef TFF_DOWN_COUNT_EN
    logic             dir_d, dir_q;
    logic [WIDTH-1:0] dn_t;
`endif

    // Toggle enables: up toggles bit i when all lower bits are 1, down when all are 0.
    always_comb begin
        up_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & count[i-1];
        end
    end

`ifdef TFF_DOWN_COUNT_EN
    always_comb begin
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            dn_t[i] = dn_t[i-1] & ~count[i-1];
        end
    end
    assign down = dir_q;
`else
    assign down = 1'b0;
`endif

    assign end_val = down ? '0 : term_q;

    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        t_vec   = '0;
        ld      = 1'b0;
        ld_val  = '0;
`ifdef TFF_DOWN_COUNT_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Wraparound maps mod_val 0 to all-ones.
                    term_d  = bus.mod_val - 1'b1;
                    ld      = 1'b1;
                    state_d = StRun;
`ifdef TFF_DOWN_COUNT_EN
                    dir_d   = bus.dir;
                    ld_val  = bus.dir ? term_d : '0;
`endif
                end
            end
            // Releasing pause resumes counting on the same edge, so each paused
            // cycle costs exactly one cycle of latency.
            StRun, StPause: begin
                if (bus.pause) begin
                    state_d = StPause;
                end else if (count == end_val) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
`ifdef TFF_DOWN_COUNT_EN
                    t_vec   = down ? dn_t : up_t;
`else
                    t_vec   = up_t;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StateRst;
            term_q  <= '0;
`ifdef TFF_DOWN_COUNT_EN
            dir_q   <= FlagRst;
`endif
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
`ifdef TFF_DOWN_COUNT_EN
            dir_q   <= dir_d;
`endif
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .clr_n (clr_n),
            .t     (t_vec[i]),
            .d     (ld_val[i]),
            .ld    (ld),
            .q     (count[i])
        );
    end

    assign bus.t_vec = t_vec;
    assign bus.count = count;
    assign bus.busy  = (state_q == StRun) || (state_q == StPause);
    assign bus.done  = (state_q == StDone);
endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed self-checking bench for tff_count_ctrl (WIDTH=4).
module tb_tff_count_ctrl;
    logic clk;
    logic clr_n;
    int   n_checks;
    int   n_errs;

    tff_count_ctrl_if #(.WIDTH(4)) bus ();

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [3:0] modv);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.mod_val = modv;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    // Up count: count 0..term after edges k..k+term, done after k+term+1.
    task automatic run_up(input logic [3:0] modv);
        int term;
        term = (modv == 4'd0) ? 15 : int'(modv) - 1;
        pulse_start(modv);
        for (int j = 0; j <= term; j++) begin
            @(negedge clk);
            check_eq("up_count", {28'd0, bus.count}, j);
            check_eq("up_busy", {31'd0, bus.busy}, 1);
            check_eq("up_nodone", {31'd0, bus.done}, 0);
        end
        @(negedge clk);
        check_eq("up_done", {31'd0, bus.done}, 1);
        check_eq("up_busy_drop", {31'd0, bus.busy}, 0);
        check_eq("up_hold", {28'd0, bus.count}, term);
        check_eq("up_tvec_done", {28'd0, bus.t_vec}, 0);
        @(negedge clk);
        check_eq("up_done_once", {31'd0, bus.done}, 0);
        check_eq("up_hold_idle", {28'd0, bus.count}, term);
    endtask

    initial begin
        n_checks    = 0;
        n_errs      = 0;
        clr_n       = 1'b0;
        bus.start   = 1'b1;
        bus.mod_val = 4'd5;
        bus.pause   = 1'b0;
`ifdef TFF_DOWN_COUNT_EN
        bus.dir     = 1'b0;
`endif
        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_count", {28'd0, bus.count}, 0);
            check_eq("rst_busy", {31'd0, bus.busy}, 0);
            check_eq("rst_done", {31'd0, bus.done}, 0);
            check_eq("rst_tvec", {28'd0, bus.t_vec}, 0);
        end
        bus.start = 1'b0;
        clr_n     = 1'b1;

        // mod 5 with t_vec spot checks
        pulse_start(4'd5);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            check_eq("m5_count", {28'd0, bus.count}, j);
            if (j == 3) check_eq("m5_tvec3", {28'd0, bus.t_vec}, 32'h7);
            if (j == 4) check_eq("m5_tvec_end", {28'd0, bus.t_vec}, 0);
        end
        @(negedge clk);
        check_eq("m5_done", {31'd0, bus.done}, 1);
        check_eq("m5_hold", {28'd0, bus.count}, 4);
        @(negedge clk);
        check_eq("m5_done_once", {31'd0, bus.done}, 0);

        run_up(4'd5);
        run_up(4'd0);
        run_up(4'd1);

        // start re-asserted while busy is ignored
        pulse_start(4'd3);
        @(negedge clk);
        check_eq("ign_c0", {28'd0, bus.count}, 0);
        bus.start   = 1'b1;
        bus.mod_val = 4'd1;
        @(negedge clk);
        bus.start   = 1'b0;
        check_eq("ign_c1", {28'd0, bus.count}, 1);
        @(negedge clk);
        check_eq("ign_c2", {28'd0, bus.count}, 2);
        check_eq("ign_busy", {31'd0, bus.busy}, 1);
        @(negedge clk);
        check_eq("ign_done", {31'd0, bus.done}, 1);
        @(negedge clk);
        check_eq("ign_idle", {31'd0, bus.busy}, 0);

        // Pause 3 cycles at count 2, mod 6: done 3 cycles later than k+6
        pulse_start(4'd6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("pz_c2", {28'd0, bus.count}, 2);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("pz_hold", {28'd0, bus.count}, 2);
            check_eq("pz_busy", {31'd0, bus.busy}, 1);
            check_eq("pz_tvec", {28'd0, bus.t_vec}, 0);
        end
        bus.pause = 1'b0;
        for (int j = 3; j <= 5; j++) begin
            @(negedge clk);
            check_eq("pz_count", {28'd0, bus.count}, j);
            check_eq("pz_nodone", {31'd0, bus.done}, 0);
        end
        @(negedge clk);
        check_eq("pz_done", {31'd0, bus.done}, 1);
        check_eq("pz_hold_end", {28'd0, bus.count}, 5);
        @(negedge clk);

        // Asynchronous reset mid-run at count 3
        pulse_start(4'd8);
        repeat (4) @(negedge clk);
        check_eq("mr_c3", {28'd0, bus.count}, 3);
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("mr_async_count", {28'd0, bus.count}, 0);
        check_eq("mr_async_busy", {31'd0, bus.busy}, 0);
        @(negedge clk);
        check_eq("mr_no_done", {31'd0, bus.done}, 0);
        clr_n = 1'b1;
        @(negedge clk);
        check_eq("mr_idle_count", {28'd0, bus.count}, 0);
        check_eq("mr_idle_busy", {31'd0, bus.busy}, 0);
        check_eq("mr_idle_done", {31'd0, bus.done}, 0);

`ifdef TFF_DOWN_COUNT_EN
        // Down count mod 4: 3,2,1,0 then done
        bus.dir = 1'b1;
        pulse_start(4'd4);
        for (int j = 3; j >= 0; j--) begin
            @(negedge clk);
            check_eq("dn_count", {28'd0, bus.count}, j);
            if (j == 2) check_eq("dn_tvec2", {28'd0, bus.t_vec}, 32'h3);
        end
        @(negedge clk);
        check_eq("dn_done", {31'd0, bus.done}, 1);
        check_eq("dn_hold", {28'd0, bus.count}, 0);
        bus.dir = 1'b0;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
